// File: rtl/inv_sched.sv
// inv_sched: round-robin scheduler that shares one fixed-latency reciprocal
// datapath between NREQ requesters. Operands are normalized (leading one at
// bit 14) before issue, a tag pipeline follows each issue through the
// datapath, and results land in per-requester response registers.
// Optional grant statistics are compiled in with INV_SCHED_STATS_EN.
//
// Handshakes: both sides use strict valid/ready. A request transfers on a
// cycle where req_valid[i] & req_ready[i]; a response transfers on a cycle
// where rsp_valid[i] & rsp_ready[i]. A raised valid is never withdrawn by the
// scheduler, and rsp_data/rsp_shift/rsp_dbz stay constant while rsp_valid is high.
module inv_sched #(
  parameter int NREQ      = 4,
  parameter int INV_LAT   = 5,
  parameter int RESWRDLEN = 24
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*15-1:0]          req_data,
  output logic [15:0]                 inv_x,
  output logic                        inv_issue,
  input  logic [RESWRDLEN-1:0]        inv_res,
  output logic [NREQ-1:0]             rsp_valid,
  input  logic [NREQ-1:0]             rsp_ready,
  output logic [NREQ*RESWRDLEN-1:0]   rsp_data,
  output logic [NREQ*4-1:0]           rsp_shift,
  output logic [NREQ-1:0]             rsp_dbz
`ifdef INV_SCHED_STATS_EN
  ,
  input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] stat_sel,
  input  logic                        stat_clr,
  output logic [15:0]                 stat_cnt
`endif
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Request-side state
  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]      inflight_q, inflight_d;
  logic                 inv_issue_q;
  logic [15:0]          inv_x_q;
  logic [IDXW-1:0]      iss_idx_q;
  logic [3:0]           iss_s_q;
  logic                 iss_dbz_q;

  // Tag pipeline running alongside the datapath
  logic [INV_LAT-1:0]   tag_vld_q;
  logic [IDXW-1:0]      tag_idx_q [INV_LAT];
  logic [3:0]           tag_s_q   [INV_LAT];
  logic [INV_LAT-1:0]   tag_dbz_q;

  // Response registers
  logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [RESWRDLEN-1:0] rsp_data_q  [NREQ];
  logic [3:0]           rsp_shift_q [NREQ];
  logic [NREQ-1:0]      rsp_dbz_q;

  // Arbitration and normalization signals
  logic [14:0]          req_op [NREQ];
  logic [NREQ-1:0]      eligible;
  logic [NREQ-1:0]      gnt;
  logic                 gnt_found;
  logic [IDXW-1:0]      gnt_idx;
  logic [14:0]          gnt_op;
  logic [3:0]           msb_pos;
  logic                 op_zero;
  logic [3:0]           norm_s;
  logic [15:0]          norm_x;

  // Exit of the tag pipeline: the datapath result for this tag is on inv_res now
  logic                 cap_v;
  logic [IDXW-1:0]      cap_idx;
  logic [3:0]           cap_s;
  logic                 cap_dbz;

  assign cap_v   = tag_vld_q[INV_LAT-1];
  assign cap_idx = tag_idx_q[INV_LAT-1];
  assign cap_s   = tag_s_q[INV_LAT-1];
  assign cap_dbz = tag_dbz_q[INV_LAT-1];

  // A requester is busy from grant until its response is accepted
  assign eligible = req_valid & ~(inflight_q | rsp_valid_q);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slices
    assign req_op[gi] = req_data[gi*15 +: 15];
    assign rsp_data[gi*RESWRDLEN +: RESWRDLEN] = rsp_data_q[gi];
    assign rsp_shift[gi*4 +: 4] = rsp_shift_q[gi];
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_dbz   = rsp_dbz_q;
  assign inv_x     = inv_x_q;
  assign inv_issue = inv_issue_q;
  assign req_ready = gnt;

  // Round-robin search for the first eligible index at or after rr_ptr
  always_comb begin
    int          idx;
    logic [IDXW-1:0] idx_v;
    gnt       = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_v = IDXW'(idx);
      if (!gnt_found && eligible[idx_v]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_v;
      end
    end
    if (!rst_n) gnt_found = 1'b0;
    if (gnt_found) gnt[gnt_idx] = 1'b1;
  end

  // Leading-one detect and left shift of the granted operand
  always_comb begin
    gnt_op  = req_op[gnt_idx];
    msb_pos = 4'd0;
    for (int b = 0; b < 15; b++) begin
      if (gnt_op[b]) msb_pos = 4'(b);
    end
    op_zero = (gnt_op == '0);
    norm_s  = op_zero ? 4'd0 : (4'd14 - msb_pos);
    norm_x  = {1'b0, gnt_op << norm_s};
  end

  // Next-state for pointer, in-flight flags and response valids
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    inflight_d  = inflight_q;
    rsp_valid_d = rsp_valid_q;
    if (gnt_found) begin
      rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDXW'(1);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) inflight_d[i] = 1'b1;
      if (cap_v && (cap_idx == IDXW'(i))) begin
        inflight_d[i]  = 1'b0;
        rsp_valid_d[i] = 1'b1;
      end else if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  // Request-side registers and the registered issue to the datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      inflight_q  <= '0;
      inv_issue_q <= 1'b0;
      inv_x_q     <= '0;
      iss_idx_q   <= '0;
      iss_s_q     <= '0;
      iss_dbz_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      inflight_q  <= inflight_d;
      inv_issue_q <= gnt_found;
      inv_x_q     <= gnt_found ? norm_x : 16'd0;
      iss_idx_q   <= gnt_idx;
      iss_s_q     <= norm_s;
      iss_dbz_q   <= op_zero;
    end
  end

  // Tag shift register: stage INV_LAT-1 lines up with the result on inv_res
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_dbz_q <= '0;
      for (int j = 0; j < INV_LAT; j++) begin
        tag_idx_q[j] <= '0;
        tag_s_q[j]   <= '0;
      end
    end else begin
      tag_vld_q[0] <= inv_issue_q;
      tag_idx_q[0] <= iss_idx_q;
      tag_s_q[0]   <= iss_s_q;
      tag_dbz_q[0] <= iss_dbz_q;
      for (int j = 1; j < INV_LAT; j++) begin
        tag_vld_q[j] <= tag_vld_q[j-1];
        tag_idx_q[j] <= tag_idx_q[j-1];
        tag_s_q[j]   <= tag_s_q[j-1];
        tag_dbz_q[j] <= tag_dbz_q[j-1];
      end
    end
  end

  // Capture returning results into the owning requester's response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_dbz_q   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        rsp_data_q[i]  <= '0;
        rsp_shift_q[i] <= '0;
      end
    end else begin
      rsp_valid_q <= rsp_valid_d;
      for (int i = 0; i < NREQ; i++) begin
        if (cap_v && (cap_idx == IDXW'(i))) begin
          rsp_data_q[i]  <= cap_dbz ? '1 : inv_res;
          rsp_shift_q[i] <= cap_s;
          rsp_dbz_q[i]   <= cap_dbz;
        end
      end
    end
  end

`ifdef INV_SCHED_STATS_EN
  logic [15:0] cnt_q [NREQ];

  assign stat_cnt = cnt_q[stat_sel];

  // Per-requester saturating grant counters with synchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inv_sched.sv
// tb_inv_sched: bench for inv_sched with default parameters. A reference
// model of the round-robin arbiter and normalizer predicts every grant and
// issue; expected responses are queued at grant time and matched when the
// DUT raises rsp_valid. The datapath is stood in for by a cycle-stamped
// inv_res pattern so that sampling at the wrong cycle shows up in rsp_data.
module tb_inv_sched;
  localparam int NREQ    = 4;
  localparam int INV_LAT = 5;
  localparam int RW      = 24;
  localparam int EW      = 8 + 32 + RW + 4 + 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*15-1:0]   req_data;
  logic [15:0]          inv_x;
  logic                 inv_issue;
  logic [RW-1:0]        inv_res;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [NREQ*RW-1:0]   rsp_data;
  logic [NREQ*4-1:0]    rsp_shift;
  logic [NREQ-1:0]      rsp_dbz;
`ifdef INV_SCHED_STATS_EN
  logic [1:0]           stat_sel;
  logic                 stat_clr;
  logic [15:0]          stat_cnt;
`endif

  always #5 clk = ~clk;

  inv_sched #(.NREQ(NREQ), .INV_LAT(INV_LAT), .RESWRDLEN(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .inv_x     (inv_x),
    .inv_issue (inv_issue),
    .inv_res   (inv_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_shift (rsp_shift),
    .rsp_dbz   (rsp_dbz)
`ifdef INV_SCHED_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Scoreboard: {idx, due cycle, data, shift, dbz}
  logic [EW-1:0] exp_q[$];

  // Reference model state
  logic [NREQ-1:0] m_busy;
  int              m_ptr;
  logic            prev_gnt_v;
  logic [15:0]     prev_x;
  logic [NREQ-1:0] prev_rsp_v;
  logic [RW-1:0]   held_data  [NREQ];
  logic [3:0]      held_shift [NREQ];
  logic            held_dbz   [NREQ];
  logic [15:0]     last_issue_x;
  logic            mon_en;

  // Input staging, applied once per cycle just after the rising edge
  logic [NREQ-1:0] drv_valid;
  logic [NREQ-1:0] drv_rdy;
  logic [14:0]     drv_data [NREQ];

  typedef struct {
    logic [14:0] data;
    logic [15:0] x;
    logic [3:0]  s;
    logic        z;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [RW-1:0] res_of(input int c);
    logic [31:0] cv;
    cv = c;
    return {cv[7:0] ^ 8'h5A, ~cv[15:0]};
  endfunction

  // Normalize by shifting until bit 14 is set
  function automatic void norm_model(input logic [14:0] d, output logic [15:0] x,
                                     output logic [3:0] s, output logic z);
    logic [14:0] t;
    t = d;
    s = 4'd0;
    z = (d == 15'd0);
    if (!z) begin
      while (!t[14]) begin
        t = t << 1;
        s = s + 4'd1;
      end
    end
    x = {1'b0, t};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic monitor();
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] exp_gnt;
    logic [EW-1:0]   e;
    logic [15:0]     mx;
    logic [3:0]      ms;
    logic            mz;
    int              g;
    int              j;
    int              found;
    elig    = req_valid & ~m_busy;
    exp_gnt = '0;
    g       = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (g < 0 && elig[j]) g = j;
    end
    if (g >= 0) exp_gnt[g] = 1'b1;
    check("req_ready", req_ready, exp_gnt);
    check("inv_issue", inv_issue, prev_gnt_v);
    if (prev_gnt_v) check("inv_x", inv_x, prev_x);
    if (inv_issue) last_issue_x = inv_x;

    for (int k = exp_q.size() - 1; k >= 0; k--) begin
      e = exp_q[k];
      if (int'(e[RW+36:RW+5]) < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_missing: requester %0d got no response, required by cycle %0d (now %0d)",
                 e[RW+44:RW+37], e[RW+36:RW+5], cyc);
        exp_q.delete(k);
      end
    end

    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid[i]) begin
        if (!prev_rsp_v[i]) begin
          found = -1;
          for (int k = 0; k < exp_q.size(); k++) begin
            e = exp_q[k];
            if (found < 0 && int'(e[RW+44:RW+37]) == i) found = k;
          end
          if (found < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_unexpected: rsp_valid[%0d] got 1 expected 0 (cycle %0d)", i, cyc);
            held_data[i]  = rsp_data[i*RW +: RW];
            held_shift[i] = rsp_shift[i*4 +: 4];
            held_dbz[i]   = rsp_dbz[i];
          end else begin
            e = exp_q[found];
            exp_q.delete(found);
            check("rsp_latency", 64'(cyc), 64'(e[RW+36:RW+5]));
            held_data[i]  = e[RW+4:5];
            held_shift[i] = e[4:1];
            held_dbz[i]   = e[0];
          end
        end
        check("rsp_data",  rsp_data[i*RW +: RW], held_data[i]);
        check("rsp_shift", rsp_shift[i*4 +: 4], held_shift[i]);
        check("rsp_dbz",   rsp_dbz[i], held_dbz[i]);
      end
    end
    prev_rsp_v = rsp_valid;

    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid[i] && rsp_ready[i]) m_busy[i] = 1'b0;
    end
    prev_gnt_v = (g >= 0);
    if (g >= 0) begin
      norm_model(drv_data[g], mx, ms, mz);
      exp_q.push_back({8'(g), 32'(cyc + INV_LAT + 2),
                       mz ? {RW{1'b1}} : res_of(cyc + INV_LAT + 1), ms, mz});
      m_busy[g] = 1'b1;
      m_ptr     = (g + 1) % NREQ;
      prev_x    = mx;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    req_valid = drv_valid;
    for (int i = 0; i < NREQ; i++) req_data[i*15 +: 15] = drv_data[i];
    rsp_ready = drv_rdy;
    inv_res   = res_of(cyc);
    #1;
    if (mon_en) monitor();
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy       = '0;
    m_ptr        = 0;
    prev_gnt_v   = 1'b0;
    prev_x       = '0;
    prev_rsp_v   = '0;
    last_issue_x = '0;
  endtask

  task automatic check_reset_outputs();
    req_valid = '1;
    #1;
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_inv_issue", inv_issue, 0);
    check("reset_inv_x",     inv_x, 0);
    req_valid = '0;
  endtask

  // Hard stop in case the bench itself stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int seen;
    vecs[0] = '{15'h4000, 16'h4000, 4'd0,  1'b0};
    vecs[1] = '{15'h0001, 16'h4000, 4'd14, 1'b0};
    vecs[2] = '{15'h0300, 16'h6000, 4'd5,  1'b0};
    vecs[3] = '{15'h0000, 16'h0000, 4'd0,  1'b1};
    vecs[4] = '{15'h7FFF, 16'h7FFF, 4'd0,  1'b0};
    vecs[5] = '{15'h0002, 16'h4000, 4'd13, 1'b0};
    vecs[6] = '{15'h1234, 16'h48D0, 4'd2,  1'b0};
    vecs[7] = '{15'h00FF, 16'h7F80, 4'd7,  1'b0};
    vecs[8] = '{15'h2AAA, 16'h5554, 4'd1,  1'b0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = '0;
    inv_res   = '0;
    drv_valid = '0;
    drv_rdy   = '0;
    for (int i = 0; i < NREQ; i++) drv_data[i] = '0;
    mon_en = 1'b0;
    model_reset();
`ifdef INV_SCHED_STATS_EN
    stat_sel = '0;
    stat_clr = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Table: one request at a time, normalization and zero handling
    for (int k = 0; k < 9; k++) begin
      int i;
      i = k % NREQ;
      drv_data[i] = vecs[k].data;
      drv_valid   = NREQ'(1 << i);
      drv_rdy     = '0;
      tick();
      drv_valid = '0;
      seen = 0;
      for (int w = 0; w < 12 && !seen; w++) begin
        tick();
        if (rsp_valid[i]) seen = 1;
      end
      check("tbl_rsp_seen",  64'(seen), 64'd1);
      check("tbl_inv_x",     last_issue_x, vecs[k].x);
      check("tbl_rsp_shift", rsp_shift[i*4 +: 4], vecs[k].s);
      check("tbl_rsp_dbz",   rsp_dbz[i], vecs[k].z);
      if (vecs[k].z) check("tbl_rsp_data_dbz", rsp_data[i*RW +: RW], {RW{1'b1}});
      drv_rdy = NREQ'(1 << i);
      tick();
      drv_rdy = '0;
    end

    // All requesters continuously active, responses accepted at once
    drv_valid = '1;
    drv_rdy   = '1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) drv_data[i] = 15'($urandom_range(0, 32767));
      tick();
    end

    // Requester 2 stalls its response for 20 cycles, then resumes
    drv_rdy = 4'b1011;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NREQ; i++) drv_data[i] = 15'($urandom_range(0, 32767));
      tick();
    end
    drv_rdy = '1;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NREQ; i++) drv_data[i] = 15'($urandom_range(0, 32767));
      tick();
    end

    // Random traffic with random back-pressure and wide operand spread
    for (int t = 0; t < 300; t++) begin
      drv_valid = NREQ'($urandom_range(0, 15));
      drv_rdy   = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++)
        drv_data[i] = 15'($urandom_range(0, 32767) >> $urandom_range(0, 15));
      tick();
    end

    // Drain
    drv_valid = '0;
    drv_rdy   = '1;
    repeat (15) tick();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with three operations in flight
    drv_valid = 4'b0111;
    drv_data[0] = 15'h0123;
    drv_data[1] = 15'h0456;
    drv_data[2] = 15'h0789;
    repeat (3) tick();
    drv_valid = '0;
    repeat (2) tick();
    check("inflight_before_reset", 64'(exp_q.size()), 64'd3);
    #2;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int t = 0; t < 15; t++) begin
      tick();
      check("rsp_after_reset", rsp_valid, 0);
    end

    // Pointer restarts at 0: requesters 0 and 3 together, 0 wins
    drv_valid   = 4'b1001;
    drv_data[0] = 15'h0300;
    drv_data[3] = 15'h0001;
    tick();
    check("post_reset_grant", req_ready, 4'b0001);
    tick();
    drv_valid = '0;
    repeat (15) tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
